// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline buffer with valid/ready handshake, 2-entry skid storage, flush and bubble masking.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage_buf #(
  parameter int                 CTRL_W   = 8,
  parameter int                 DATA_W   = 121,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  logic              main_vld_p0;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic              skid_vld_p1;
  logic [CTRL_W-1:0] skid_ctrl_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic              accept;
  logic              drain;

  assign in_ready_o  = !skid_vld_p1;
  assign accept      = in_valid_i & in_ready_o & !flush_i;
  assign drain       = main_vld_p0 & out_ready_i;
  assign out_valid_o = main_vld_p0;
  assign ctrl_o      = main_vld_p0 ? main_ctrl_p0 : CTRL_RST;
  assign data_o      = main_data_p0;
  assign occ_o       = 2'(main_vld_p0) + 2'(skid_vld_p1);

  // Skid entry is only ever filled behind a full main entry, so it always refills main first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_vld_p0  <= 1'b0;
      main_ctrl_p0 <= CTRL_RST;
      main_data_p0 <= '0;
      skid_vld_p1  <= 1'b0;
      skid_ctrl_p1 <= CTRL_RST;
      skid_data_p1 <= '0;
    end else if (flush_i) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1) begin
      if (drain) begin
        main_ctrl_p0 <= skid_ctrl_p1;
        main_data_p0 <= skid_data_p1;
        skid_vld_p1  <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_p0 || drain) begin
        main_vld_p0  <= 1'b1;
        main_ctrl_p0 <= ctrl_i;
        main_data_p0 <= data_i;
      end else begin
        skid_vld_p1  <= 1'b1;
        skid_ctrl_p1 <= ctrl_i;
        skid_data_p1 <= data_i;
      end
    end else if (drain) begin
      main_vld_p0 <= 1'b0;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Counts upstream offers refused by a full buffer; sticks at all-ones, survives flush.
  logic [15:0] stall_cnt_p0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_p0 <= '0;
    end else if (in_valid_i && !in_ready_o && stall_cnt_p0 != 16'hFFFF) begin
      stall_cnt_p0 <= stall_cnt_p0 + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_p0;
`endif

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Randomised and directed bench for id_ex_stage_buf against a queue-based FIFO model.
module tb_id_ex_stage_buf;
  localparam int CW = 8;
  localparam int DW = 121;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [1:0]    occ_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  id_ex_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(8'h00)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .occ_o(occ_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_data;
  int            m_stall;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    last_data = '0;
    m_stall   = 0;
  endfunction

  // Model of one clock edge: a FIFO of depth two, head is what the outputs show.
  function automatic void model_edge(logic iv, logic [CW-1:0] c, logic [DW-1:0] d,
                                     logic ordy, logic fl);
    bit rdy, drn, acc;
    if (!rst_i) begin
      model_reset();
      return;
    end
    rdy = (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    acc = iv && rdy && !fl;
    if (iv && !rdy && m_stall < 16'hFFFF) m_stall++;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{c: c, d: d});
    end
    if (q.size() > 0) last_data = q[0].d;
  endfunction

  function automatic void compare();
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ev = (q.size() > 0);
    ec = ev ? q[0].c : 8'h00;
    ed = ev ? q[0].d : last_data;
    chk("out_valid", 128'(out_valid_o), 128'(ev));
    chk("ctrl_o",    128'(ctrl_o),      128'(ec));
    chk("data_o",    128'(data_o),      128'(ed));
    chk("in_ready",  128'(in_ready_o),  128'(q.size() < 2));
    chk("occ",       128'(occ_o),       128'(q.size()));
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_cnt", 128'(stall_cnt_o), 128'(m_stall));
`endif
  endfunction

  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    in_valid_i  = iv;
    ctrl_i      = c;
    data_i      = d;
    out_ready_i = ordy;
    flush_i     = fl;
    @(posedge clk_i);
    model_edge(iv, c, d, ordy, fl);
    @(negedge clk_i);
    compare();
  endtask

  logic [127:0] r;

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    ctrl_i = '0; data_i = '0;
    model_reset();
    @(negedge clk_i);
    compare();
    step(1'b1, 8'h11, DW'(32'h99), 1'b1, 1'b0);  // no acceptance while in reset
    chk("rst_occ_lit", 128'(occ_o), 128'(0));
    rst_i = 1'b1;
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);

    // Streaming
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), DW'(i), 1'b1, 1'b0);
      chk("stream_data_lit", 128'(data_o), 128'(i));
      chk("stream_occ_lit",  128'(occ_o),  128'(1));
    end
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);

    // Backpressure
    step(1'b1, 8'h0A, DW'(32'hA), 1'b0, 1'b0);
    step(1'b1, 8'h0B, DW'(32'hB), 1'b0, 1'b0);
    chk("bp_occ_lit",   128'(occ_o),      128'(2));
    chk("bp_ready_lit", 128'(in_ready_o), 128'(0));
    chk("bp_headA_lit", 128'(data_o),     128'(32'hA));
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);
    chk("bp_headB_lit", 128'(data_o),     128'(32'hB));
    chk("bp_rdy1_lit",  128'(in_ready_o), 128'(1));
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);

    // Flush with occupancy two and an entry offered
    step(1'b1, 8'h21, DW'(32'h1), 1'b0, 1'b0);
    step(1'b1, 8'h22, DW'(32'h2), 1'b0, 1'b0);
    step(1'b1, 8'h3C, DW'(32'hC), 1'b0, 1'b1);
    chk("fl_occ_lit",  128'(occ_o),  128'(0));
    chk("fl_ctrl_lit", 128'(ctrl_o), 128'(0));
    step(1'b1, 8'h3D, DW'(32'hD), 1'b1, 1'b0);
    chk("fl_D_lit", 128'(data_o), 128'(32'hD));
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);

    // Bubble masking
    step(1'b1, 8'hFF, DW'(32'h77), 1'b1, 1'b0);
    chk("bub_ctrl_lit", 128'(ctrl_o), 128'(8'hFF));
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);
    chk("bub_mask_lit", 128'(ctrl_o), 128'(0));
    chk("bub_hold_lit", 128'(data_o), 128'(32'h77));

    // Asynchronous reset mid-stream with occupancy two
    step(1'b1, 8'h41, DW'(32'h41), 1'b0, 1'b0);
    step(1'b1, 8'h42, DW'(32'h42), 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    model_reset();
    compare();
    chk("arst_data_lit",  128'(data_o),     128'(0));
    chk("arst_ready_lit", 128'(in_ready_o), 128'(1));
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b0);
    rst_i = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      rst_i = ($urandom_range(0, 299) != 0);
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), r[DW-1:0],
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    rst_i = 1'b1;
    step(1'b0, 8'h00, DW'(0), 1'b1, 1'b1);

`ifdef ID_EX_STALL_CNT_EN
    step(1'b1, 8'h51, DW'(32'h51), 1'b0, 1'b0);
    step(1'b1, 8'h52, DW'(32'h52), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1, 8'h53, DW'(32'h53), 1'b0, 1'b0);
    chk("stall_sat_lit", 128'(stall_cnt_o), 128'(16'hFFFF));
    step(1'b0, 8'h00, DW'(0), 1'b0, 1'b1);
    chk("stall_flush_lit", 128'(stall_cnt_o), 128'(16'hFFFF));
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("stall_rst_lit", 128'(stall_cnt_o), 128'(0));
    rst_i = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_buf.md
Name: id_ex_stage_buf

Overview:
- Parametrised successor to the fixed ID/EX latch.
- Carries a control bundle and a data bundle between decode and execute.
- Adds a valid/ready handshake, a 2-entry skid buffer so backpressure does not form a combinational ready chain, a synchronous flush that inserts a bubble, and control masking on bubbles.
- Placed between hazard/decode logic and the EX stage; the same block is reused for EX/MEM and MEM/WB by changing parameters.

Parameters:
- CTRL_W, 8: control bundle width (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, spare).
- DATA_W, 121: data bundle width (rs1 data, rs2 data, imm, funct7/funct3, rs1, rs2, rd).
- CTRL_RST, 0: reset/bubble value of ctrl_o, CTRL_W bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush (branch taken / load-use bubble).
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  block can accept an entry this cycle.
- ctrl_i  in  CTRL_W  upstream control bundle.
- data_i  in  DATA_W  upstream data bundle.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts output this cycle.
- ctrl_o  out  CTRL_W  output control; CTRL_RST when out_valid_o=0.
- data_o  out  DATA_W  output data; holds last value when invalid.
- occ_o  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- in_ready_o = !skid_valid. It is registered state, with no combinational path from out_ready_i.
- Accept = in_valid_i & in_ready_o & !flush_i.
- Drain = out_valid_o & out_ready_i.
- Per-cycle update when flush_i=0:
  - main empty, accept: entry goes to main. Next cycle out_valid_o=1, occ=1.
  - main full, drain, skid empty, accept: main loads the new entry; occ stays 1.
  - main full, drain, skid empty, no accept: main goes empty; occ=0.
  - main full, no drain, accept: entry goes to skid; in_ready_o=0 next cycle; occ=2.
  - skid full, drain: skid moves to main, skid empties, in_ready_o=1 next cycle, occ=1. No accept is possible this cycle.
  - skid full, no drain: hold everything.
- Latency: an accepted entry appears on the outputs 1 cycle later when main is empty or draining.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush.
- flush_i=1 (synchronous):
  - Next cycle both valids are 0, occ=0, in_ready_o=1.
  - Any entry offered the same cycle is dropped.
  - A drain occurring the same cycle still counts as taken downstream.
- Bubble masking: ctrl_o = out_valid_o ? main_ctrl : CTRL_RST. This is combinational on the registered valid.
- Data registers are not cleared on flush.
- Reset (rst_i=0, any time, including mid-transfer):
  - Both valids 0, ctrl regs = CTRL_RST, data regs = 0.
  - out_valid_o=0, in_ready_o=1, occ_o=0, ctrl_o=CTRL_RST, data_o=0.
- Reset deassertion: no acceptance on the first edge where rst_i is sampled low.
- Simultaneous flush and reset: reset wins.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits).
  - Increments each cycle with in_valid_i=1 & in_ready_o=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset, not by flush.
- When undefined: the port and counter are absent and the block is otherwise identical.

Test Plan:
- Reset: rst_i low mid-stream with occ=2 -> immediately out_valid_o=0, ctrl_o=0, data_o=0, in_ready_o=1, occ_o=0.
- Streaming: out_ready_i=1, entries data 0x1..0x5 offered back to back -> same values on data_o one cycle later each, occ_o stays 1, in_ready_o never low.
- Backpressure: out_ready_i=0 after entry A=0xA; offer B=0xB -> B accepted, occ=2, in_ready_o=0. Raise out_ready_i -> A then B on consecutive cycles, in_ready_o returns to 1.
- Flush: occ=2 with flush_i=1 and C offered -> next cycle occ=0 and ctrl_o=0. C never appears; the next offered D=0xD appears normally.
- Bubble masking: ctrl_i=8'hFF accepted, then drained with no new input -> ctrl_o=8'h00 while out_valid_o=0 and data_o holds its last value.
- ID_EX_STALL_CNT_EN: hold out_ready_i=0 with occ=2 for 70000 cycles -> stall_cnt_o=16'hFFFF. Flush leaves it at 16'hFFFF; reset returns it to 0.
